// File: rtl/apb_cfg_master_pkg.sv
// Shared opcodes and FSM encoding for the APB configuration master.
package apb_cfg_master_pkg;

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_POLL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    function automatic logic op_is_write(input logic [1:0] op);
        return op == OP_WR;
    endfunction

endpackage

// File: rtl/apb_cfg_master_cmd_fifo.sv
// Synchronous command FIFO with count-derived full/empty; head visible combinationally.
// Push is ignored when full, pop ignored when empty; full does not look at a same-cycle pop.
module apb_cfg_master_cmd_fifo #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_full     = (r_cnt == CNT_W'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign o_head_dat = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/apb_cfg_master.sv
// APB initiator running queued write/read/poll commands; first PSEL two cycles after push.
// cmd_ready is !full of the command FIFO; responses are single-cycle pulses with no backpressure.
module apb_cfg_master
    import apb_cfg_master_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_GAP   = 4,
    parameter int POLL_MAX   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);
    localparam int ENT_W = 2 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W = $clog2(POLL_GAP + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic [DATA_W-1:0] r_mask;
    logic [CNT_W-1:0]  r_poll_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_rsp_vld;
    logic [DATA_W-1:0] r_rsp_dat;
    logic              r_rsp_err;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ENT_W-1:0]  w_head;
    logic [1:0]        w_head_op;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_dat;
    logic              w_rsp;
    logic              w_err;
    logic              w_release;
    logic              w_hit;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_poll_cnt_inc;

    assign w_push = cmd_valid && !w_full;

    apb_cfg_master_cmd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_push     (w_push),
        .i_push_dat ({cmd_op, cmd_addr, cmd_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign {w_head_op, w_head_addr, w_head_dat} = w_head;

    assign w_poll_cnt_inc = r_poll_cnt + CNT_W'(1);
    assign w_hit          = |(PRDATA & r_mask);
    assign w_timeout      = (w_poll_cnt_inc == CNT_W'(POLL_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_rsp       = 1'b0;
        w_err       = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    if (r_op == OP_POLL) begin
                        if (w_hit || w_timeout) begin
                            w_rsp     = 1'b1;
                            w_err     = !w_hit;
                            w_release = 1'b1;
                        end else begin
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
                        // Reserved opcode behaves as a read.
                        w_rsp     = !op_is_write(r_op);
                        w_release = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A finished command chains straight into the next SETUP when one is queued.
        if (w_release) begin
            if (!w_empty) begin
                w_pop       = 1'b1;
                w_state_nxt = ST_SETUP;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op       <= OP_WR;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_mask     <= '0;
            r_poll_cnt <= '0;
            r_gap_cnt  <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_dat  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_pop) begin
                r_op     <= w_head_op;
                r_paddr  <= w_head_addr;
                r_pwdata <= op_is_write(w_head_op) ? w_head_dat : '0;
                r_mask   <= w_head_dat;
            end
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
            if ((r_state == ST_ACCESS) && PREADY && (r_op == OP_POLL)) begin
                r_poll_cnt <= w_rsp ? '0 : w_poll_cnt_inc;
            end
            r_rsp_vld <= w_rsp;
            r_rsp_err <= w_err;
            if (w_rsp) begin
                r_rsp_dat <= PRDATA;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign busy      = (r_state != ST_IDLE) || !w_empty;
    assign PSEL      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign PENABLE   = (r_state == ST_ACCESS);
    assign PWRITE    = PSEL && op_is_write(r_op);
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_vld;
    assign rsp_data  = r_rsp_dat;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Bench for apb_cfg_master: directed vector table, multi-cycle sequences, randomized run vs reference model.
module tb_apb_cfg_master;
    import apb_cfg_master_pkg::*;

    localparam int POLL_MAX = 3;
    localparam int POLL_GAP = 4;
    localparam int DEPTH    = 4;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    apb_cfg_master #(
        .ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(DEPTH), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          acc;
        int          setup_cyc;
        int          end_cyc;
    } xfer_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wd;
    } exp_x_t;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] sval;
        int          wt;
        int          nx;
        logic        wr;
        logic [31:0] wd;
        int          acc;
        int          rv;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    xfer_t       xq[$];
    rsp_t        rq[$];
    exp_x_t      ex_xq[$];
    rsp_t        ex_rq[$];
    logic [31:0] smem[256];
    logic [31:0] mmem[256];
    logic [31:0] rd_q[$];
    int          slave_wait = 0;
    bit          slave_hold = 0;
    bit          slave_rand = 0;
    bit          model_on = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus monitor: transfer log, response log, APB protocol checks
    initial begin
        logic [7:0]  m_addr;
        logic        m_wr;
        logic [31:0] m_wd;
        int          m_acc;
        int          m_setup;
        m_addr = '0; m_wr = 1'b0; m_wd = '0; m_acc = 0; m_setup = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (PSEL && !PENABLE) begin
                    m_addr = PADDR; m_wr = PWRITE; m_wd = PWDATA; m_acc = 0; m_setup = cyc;
                end else if (PSEL && PENABLE) begin
                    m_acc++;
                    check("access_stable", {PADDR, PWRITE, PWDATA}, {m_addr, m_wr, m_wd});
                    if (PREADY) xq.push_back('{m_wr, m_addr, m_wd, PRDATA, m_acc, m_setup, cyc});
                end else begin
                    check("apb_idle", {PENABLE, PWRITE}, 2'b00);
                end
                if (rsp_valid) rq.push_back('{rsp_data, rsp_err, cyc});
            end
        end
    end

    // APB slave: memory, optional read-data override queue, configurable wait states
    initial begin
        int wl;
        wl = 0;
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                PREADY = 1'b0;
            end else if (PSEL && !PENABLE) begin
                PREADY = 1'b0;
                wl = slave_rand ? int'($urandom_range(0, 2)) : slave_wait;
            end else if (PSEL && PENABLE) begin
                if (!slave_hold && wl == 0) begin
                    PREADY = 1'b1;
                    if (PWRITE) smem[PADDR] = PWDATA;
                    else PRDATA = (rd_q.size() > 0) ? rd_q.pop_front() : smem[PADDR];
                end else begin
                    PREADY = 1'b0;
                    PRDATA = $urandom;
                    if (!slave_hold) wl--;
                end
            end else begin
                PREADY = 1'b0;
            end
        end
    end

    // Reference model: per-command effect on the bus and response stream
    task automatic model_push(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
        int k;
        if (op == OP_WR) begin
            mmem[a] = d;
            ex_xq.push_back('{1'b1, a, d});
        end else if (op == OP_POLL) begin
            k = ((mmem[a] & d) != 0) ? 1 : POLL_MAX;
            repeat (k) ex_xq.push_back('{1'b0, a, 32'h0});
            ex_rq.push_back('{mmem[a], ((mmem[a] & d) == 0), 0});
        end else begin
            ex_xq.push_back('{1'b0, a, 32'h0});
            ex_rq.push_back('{mmem[a], 1'b0, 0});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                            output int pc);
        int n;
        bit acc;
        n = 0; acc = 0; pc = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        while (!acc && n < 3000) begin
            acc = cmd_ready;
            pc = cyc;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        check("push_accepted", acc, 1'b1);
        if (acc && model_on) model_push(op, a, d);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            step();
            n++;
        end
        check("idle_reached", busy, 1'b0);
        repeat (3) step();
    endtask

    initial begin
        vec_t        vt[6];
        int          pc;
        int          pc6;
        int          rel_cyc;
        int          n;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [31:0] d;

        vt[0] = '{OP_WR,   8'h04, 32'h0000_00A5, 32'h0,         0, 1, 1'b1, 32'h0000_00A5, 1, 0, 32'h0,         1'b0};
        vt[1] = '{OP_RD,   8'h10, 32'hFFFF_0000, 32'h0000_1234, 3, 1, 1'b0, 32'h0,         4, 1, 32'h0000_1234, 1'b0};
        vt[2] = '{2'd3,    8'h20, 32'h0000_0001, 32'hDEAD_BEEF, 1, 1, 1'b0, 32'h0,         2, 1, 32'hDEAD_BEEF, 1'b0};
        vt[3] = '{OP_POLL, 8'h30, 32'h0000_0001, 32'h0000_0003, 0, 1, 1'b0, 32'h0,         1, 1, 32'h0000_0003, 1'b0};
        vt[4] = '{OP_POLL, 8'h34, 32'h0000_0008, 32'h0000_0007, 2, 3, 1'b0, 32'h0,         3, 1, 32'h0000_0007, 1'b1};
        vt[5] = '{OP_WR,   8'hFC, 32'hFFFF_FFFF, 32'h0,         1, 1, 1'b1, 32'hFFFF_FFFF, 2, 0, 32'h0,         1'b0};

        for (int i = 0; i < 256; i++) smem[i] = $urandom;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_data, rsp_err, busy},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0});
        reset = 1'b0;
        step();

        // Single-command vectors
        for (int i = 0; i < 6; i++) begin
            xq.delete(); rq.delete();
            smem[vt[i].addr] = vt[i].sval;
            slave_wait = vt[i].wt;
            push_cmd(vt[i].op, vt[i].addr, vt[i].data, pc);
            wait_idle();
            check($sformatf("vec%0d_nxfers", i), xq.size(), vt[i].nx);
            if (xq.size() > 0) begin
                check($sformatf("vec%0d_pwrite", i), xq[xq.size()-1].wr, vt[i].wr);
                check($sformatf("vec%0d_paddr", i), xq[xq.size()-1].addr, vt[i].addr);
                check($sformatf("vec%0d_pwdata", i), xq[xq.size()-1].wd, vt[i].wd);
                check($sformatf("vec%0d_access_cycles", i), xq[xq.size()-1].acc, vt[i].acc);
                if (i == 0) check("first_setup_latency", xq[0].setup_cyc - pc, 2);
            end
            check($sformatf("vec%0d_rsp_count", i), rq.size(), vt[i].rv);
            if (rq.size() > 0) begin
                check($sformatf("vec%0d_rsp_data", i), rq[0].d, vt[i].rd);
                check($sformatf("vec%0d_rsp_err", i), rq[0].e, vt[i].err);
            end
        end

        // FIFO full while the slave stalls, then back-to-back drain
        xq.delete(); rq.delete();
        slave_wait = 0; slave_hold = 1;
        for (int i = 0; i < 5; i++) push_cmd(OP_WR, 8'h60 + 8'(i * 4), 32'h100 + i, pc);
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        check("held_no_xfer", xq.size(), 0);
        rel_cyc = 0; pc6 = -1;
        fork
            push_cmd(OP_WR, 8'h74, 32'h105, pc6);
            begin
                repeat (6) @(posedge clk);
                #2;
                rel_cyc = cyc;
                slave_hold = 0;
            end
        join
        check("sixth_push_after_release", pc6 > rel_cyc, 1'b1);
        wait_idle();
        check("full_nxfers", xq.size(), 6);
        for (int i = 0; i < 6 && i < xq.size(); i++) begin
            check($sformatf("order%0d_addr", i), xq[i].addr, 8'h60 + 8'(i * 4));
            check($sformatf("order%0d_wdata", i), xq[i].wd, 32'h100 + i);
            if (i > 0) check($sformatf("b2b%0d", i), xq[i].setup_cyc, xq[i-1].end_cyc + 1);
        end
        check("full_no_rsp", rq.size(), 0);

        // Poll succeeding on the third read, followed by a queued write
        xq.delete(); rq.delete();
        rd_q = {32'h0, 32'h0, 32'h1};
        push_cmd(OP_POLL, 8'h40, 32'h1, pc);
        push_cmd(OP_WR, 8'h44, 32'h55, pc);
        wait_idle();
        check("poll_nxfers", xq.size(), 4);
        check("poll_rdq_drained", rd_q.size(), 0);
        if (xq.size() == 4) begin
            check("poll_gap1", xq[1].setup_cyc - xq[0].end_cyc - 1, POLL_GAP);
            check("poll_gap2", xq[2].setup_cyc - xq[1].end_cyc - 1, POLL_GAP);
            check("poll_next_is_write", {xq[3].wr, xq[3].addr}, {1'b1, 8'h44});
        end
        check("poll_rsp_count", rq.size(), 1);
        if (rq.size() == 1 && xq.size() == 4) begin
            check("poll_rsp", {rq[0].d, rq[0].e}, {32'h1, 1'b0});
            check("poll_blocks_next", xq[3].setup_cyc >= rq[0].cyc, 1'b1);
        end
        check("rsp_data_held", rsp_data, 32'h1);

        // Asynchronous reset in the middle of a stalled ACCESS
        xq.delete(); rq.delete();
        slave_hold = 1;
        push_cmd(OP_RD, 8'h50, 32'h0, pc);
        n = 0;
        while (!PENABLE && n < 100) begin
            step();
            n++;
        end
        check("reached_access", PENABLE, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", {PSEL, PENABLE, cmd_ready, busy, rsp_valid},
              {1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        slave_hold = 0;
        repeat (3) step();
        check("reset_no_rsp", rq.size(), 0);
        check("reset_no_xfer", xq.size(), 0);
        push_cmd(OP_WR, 8'h54, 32'h99, pc);
        wait_idle();
        check("post_reset_nxfers", xq.size(), 1);
        if (xq.size() == 1) check("post_reset_xfer", {xq[0].wr, xq[0].addr, xq[0].wd}, {1'b1, 8'h54, 32'h99});

        // Randomized command stream against the reference model
        xq.delete(); rq.delete(); ex_xq.delete(); ex_rq.delete();
        for (int i = 0; i < 256; i++) mmem[i] = smem[i];
        slave_rand = 1; model_on = 1;
        for (int i = 0; i < 80; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 15) * 4);
            d  = (op == OP_POLL) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
            push_cmd(op, a, d, pc);
            repeat ($urandom_range(0, 2)) step();
        end
        wait_idle();
        model_on = 0; slave_rand = 0;
        check("rand_nxfers", xq.size(), ex_xq.size());
        check("rand_nrsp", rq.size(), ex_rq.size());
        for (int i = 0; i < xq.size() && i < ex_xq.size(); i++)
            check($sformatf("rand_xfer%0d", i), {xq[i].wr, xq[i].addr, xq[i].wd},
                  {ex_xq[i].wr, ex_xq[i].addr, ex_xq[i].wd});
        for (int i = 0; i < rq.size() && i < ex_rq.size(); i++)
            check($sformatf("rand_rsp%0d", i), {rq[i].d, rq[i].e}, {ex_rq[i].d, ex_rq[i].e});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
